// File: rtl/rs_pkg.sv
// Shared constants and types for the RS(31,27) encoder over GF(2^5), p(x) = x^5 + x^2 + 1.
package rs_pkg;

  localparam int RS_N    = 31;
  localparam int RS_K    = 27;
  localparam int RS_NPAR = 4;

  localparam logic [4:0] GF_POLY = 5'b00101;

  typedef logic [4:0] sym_t;

  // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots alpha^1..alpha^4
  localparam sym_t G0 = 5'd17;
  localparam sym_t G1 = 5'd9;
  localparam sym_t G2 = 5'd6;
  localparam sym_t G3 = 5'd30;

  typedef enum logic [0:0] {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } state_t;

  function automatic sym_t gf_xtime(input sym_t a);
    return a[4] ? ({a[3:0], 1'b0} ^ GF_POLY) : {a[3:0], 1'b0};
  endfunction

endpackage

// File: rtl/gf_const_mult.sv
// GF(2^5) multiply by a fixed constant C; combinational XOR network.
module gf_const_mult
  import rs_pkg::*;
#(
  parameter logic [4:0] C = 5'd1
) (
  input  logic [4:0] i_a,
  output logic [4:0] o_p
);

  // Column k is C * alpha^k, folded at elaboration; only XORs remain.
  localparam sym_t COL0 = C;
  localparam sym_t COL1 = gf_xtime(COL0);
  localparam sym_t COL2 = gf_xtime(COL1);
  localparam sym_t COL3 = gf_xtime(COL2);
  localparam sym_t COL4 = gf_xtime(COL3);

  assign o_p = ({5{i_a[0]}} & COL0) ^ ({5{i_a[1]}} & COL1) ^ ({5{i_a[2]}} & COL2)
             ^ ({5{i_a[3]}} & COL3) ^ ({5{i_a[4]}} & COL4);

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(31,27) encoder: forwards 27 message symbols, then 4 LFSR parity symbols.
// One-cycle registered latency; in_ready drops for the 4 parity cycles, no output backpressure.
module rs_encoder
  import rs_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [4:0] data_in,
  output logic       in_ready,
  output logic       out_valid,
  output logic [4:0] data_out,
  output logic       out_sop,
  output logic       out_eop
);

  localparam logic [4:0] LAST_SYM = 5'(RS_K - 1);
  localparam logic [1:0] LAST_PAR = 2'(RS_NPAR - 1);

  state_t     r_state;
  sym_t       r_p0, r_p1, r_p2, r_p3;
  logic [4:0] r_sym_cnt;
  logic [1:0] r_par_cnt;
  logic       r_out_valid, r_out_sop, r_out_eop;
  sym_t       r_data_out;

  logic w_accept;
  sym_t w_fb, w_fb_g0, w_fb_g1, w_fb_g2, w_fb_g3;

  assign in_ready = (r_state == ST_DATA);
  assign w_accept = in_valid && in_ready;
  assign w_fb     = data_in ^ r_p3;

  gf_const_mult #(.C(G0)) u_mul_g0 (.i_a(w_fb), .o_p(w_fb_g0));
  gf_const_mult #(.C(G1)) u_mul_g1 (.i_a(w_fb), .o_p(w_fb_g1));
  gf_const_mult #(.C(G2)) u_mul_g2 (.i_a(w_fb), .o_p(w_fb_g2));
  gf_const_mult #(.C(G3)) u_mul_g3 (.i_a(w_fb), .o_p(w_fb_g3));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_DATA;
      r_p0        <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_p3        <= '0;
      r_sym_cnt   <= '0;
      r_par_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      if (r_state == ST_DATA) begin
        if (w_accept) begin
          r_p3        <= r_p2 ^ w_fb_g3;
          r_p2        <= r_p1 ^ w_fb_g2;
          r_p1        <= r_p0 ^ w_fb_g1;
          r_p0        <= w_fb_g0;
          r_data_out  <= data_in;
          r_out_valid <= 1'b1;
          r_out_sop   <= (r_sym_cnt == 5'd0);
          if (r_sym_cnt == LAST_SYM) begin
            r_sym_cnt <= '0;
            r_state   <= ST_PARITY;
          end else begin
            r_sym_cnt <= r_sym_cnt + 5'd1;
          end
        end
      end else begin
        // Shifting zeros in leaves the LFSR clear for the next codeword.
        r_data_out  <= r_p3;
        r_out_valid <= 1'b1;
        r_out_eop   <= (r_par_cnt == LAST_PAR);
        r_p3        <= r_p2;
        r_p2        <= r_p1;
        r_p1        <= r_p0;
        r_p0        <= '0;
        if (r_par_cnt == LAST_PAR) begin
          r_par_cnt <= '0;
          r_state   <= ST_DATA;
        end else begin
          r_par_cnt <= r_par_cnt + 2'd1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;

endmodule
